// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding-select encodings,
// Tuse sentinel, mult/div latencies and the register-address helper.
package hazard_unit_pkg;

  localparam int REG_AW          = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_e;

  // $zero is hard-wired, so a producer targeting it never satisfies a consumer.
  function automatic logic addr_hit(input logic [REG_AW-1:0] a,
                                    input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_unit_md_busy_ctr.sv
// Mult/div occupancy counter: loads the operation latency on a start and
// counts down to zero; busy while non-zero. A new start reloads, never queues.
module md_busy_ctr #(
  parameter int CNT_W       = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start_mult_i,
  input  logic start_div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Divide wins if both starts arrive together.
  always_comb begin
    cnt_d = cnt_q;
    if (start_div_i) begin
      cnt_d = CNT_W'(DIV_CYCLES);
    end else if (start_mult_i) begin
      cnt_d = CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// D-stage hazard detection for the 5-stage MIPS core: Tuse/Tnew stall,
// D/E/M forwarding selects, mult/div busy tracking and a stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] A1,
  input  logic [REG_AW-1:0] A2,
  input  logic [1:0]        Tuse_rs,
  input  logic [1:0]        Tuse_rt,
  input  logic              D_md,
  input  logic [REG_AW-1:0] DEA1,
  input  logic [REG_AW-1:0] DEA2,
  input  logic [REG_AW-1:0] DEA3,
  input  logic [1:0]        DETnew,
  input  logic [REG_AW-1:0] EMA2,
  input  logic [REG_AW-1:0] EMA3,
  input  logic [1:0]        EMTnew,
  input  logic [REG_AW-1:0] MWA3,
  input  logic              E_mult,
  input  logic              E_div,
  input  logic              ExcClr,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  md_busy_ctr #(
    .CNT_W       (CNT_W),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk          (clk),
    .rst          (reset),
    .start_mult_i (E_mult & ~ExcClr),
    .start_div_i  (E_div & ~ExcClr),
    .busy_o       (md_busy)
  );

  // Stall when a producer's result arrives later than the consumer needs it.
  always_comb begin
    stall_rs = (addr_hit(A1, DEA3) && (DETnew > Tuse_rs)) ||
               (addr_hit(A1, EMA3) && (EMTnew > Tuse_rs));
    stall_rt = (addr_hit(A2, DEA3) && (DETnew > Tuse_rt)) ||
               (addr_hit(A2, EMA3) && (EMTnew > Tuse_rt));
    stall_md = D_md && (md_busy || E_mult || E_div);
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Youngest ready producer wins: E over M over W.
  always_comb begin
    fwd_rs_d = FWD_RF;
    fwd_rt_d = FWD_RF;
    fwd_rs_e = FWD_RF;
    fwd_rt_e = FWD_RF;
    if (addr_hit(A1, DEA3) && DETnew == 2'd0)      fwd_rs_d = FWD_E;
    else if (addr_hit(A1, EMA3) && EMTnew == 2'd0) fwd_rs_d = FWD_M;
    else if (addr_hit(A1, MWA3))                   fwd_rs_d = FWD_W;
    if (addr_hit(A2, DEA3) && DETnew == 2'd0)      fwd_rt_d = FWD_E;
    else if (addr_hit(A2, EMA3) && EMTnew == 2'd0) fwd_rt_d = FWD_M;
    else if (addr_hit(A2, MWA3))                   fwd_rt_d = FWD_W;
    if (addr_hit(DEA1, EMA3) && EMTnew == 2'd0)    fwd_rs_e = FWD_M;
    else if (addr_hit(DEA1, MWA3))                 fwd_rs_e = FWD_W;
    if (addr_hit(DEA2, EMA3) && EMTnew == 2'd0)    fwd_rt_e = FWD_M;
    else if (addr_hit(DEA2, MWA3))                 fwd_rt_e = FWD_W;
    fwd_rt_m = addr_hit(EMA2, MWA3);
  end

  // Flushed cycles are not counted as stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !ExcClr) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, DEA1, DEA2, DEA3, EMA2, EMA3, MWA3;
  logic [1:0]  Tuse_rs, Tuse_rt, DETnew, EMTnew;
  logic        D_md, E_mult, E_div, ExcClr;
  logic        stall, fwd_rt_m, md_busy;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [31:0] stall_cnt;

  int          checks = 0;
  int          passes = 0;
  int          mdl_cnt;
  logic [31:0] mdl_stall_cnt;

  hazard_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .D_md(D_md), .DEA1(DEA1), .DEA2(DEA2), .DEA3(DEA3), .DETnew(DETnew),
    .EMA2(EMA2), .EMA3(EMA3), .EMTnew(EMTnew), .MWA3(MWA3), .E_mult(E_mult),
    .E_div(E_div), .ExcClr(ExcClr), .stall(stall), .fwd_rs_d(fwd_rs_d),
    .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // A source stalls if some in-flight producer writes it and is not ready by Tuse.
  function automatic logic mdl_src_stall(input logic [4:0] a, input logic [1:0] tuse);
    int need, e_ready, m_ready;
    need    = int'(tuse);
    e_ready = int'(DETnew);
    m_ready = int'(EMTnew);
    if (a == 5'd0) return 1'b0;
    if (a == DEA3 && e_ready > need) return 1'b1;
    if (a == EMA3 && m_ready > need) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mdl_stall();
    logic md_wait;
    md_wait = D_md && (mdl_cnt > 0 || E_mult || E_div);
    return mdl_src_stall(A1, Tuse_rs) || mdl_src_stall(A2, Tuse_rt) || md_wait;
  endfunction

  function automatic logic [1:0] mdl_fwd_d(input logic [4:0] a);
    if (a == 5'd0) return 2'd0;
    if (a == DEA3 && DETnew == 2'd0) return 2'd1;
    if (a == EMA3 && EMTnew == 2'd0) return 2'd2;
    if (a == MWA3) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] mdl_fwd_e(input logic [4:0] a);
    if (a == 5'd0) return 2'd0;
    if (a == EMA3 && EMTnew == 2'd0) return 2'd2;
    if (a == MWA3) return 2'd3;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    A1 = 0; A2 = 0; DEA1 = 0; DEA2 = 0; DEA3 = 0; EMA2 = 0; EMA3 = 0; MWA3 = 0;
    Tuse_rs = TUSE_NONE; Tuse_rt = TUSE_NONE; DETnew = 0; EMTnew = 0;
    D_md = 0; E_mult = 0; E_div = 0; ExcClr = 0;
  endtask

  // Advance one clock; the model sees the inputs that were stable at the edge.
  task automatic tick();
    logic st;
    st = mdl_stall();
    @(posedge clk);
    if (st && !ExcClr) mdl_stall_cnt = mdl_stall_cnt + 32'd1;
    if (E_div && !ExcClr) mdl_cnt = DIV_N;
    else if (E_mult && !ExcClr) mdl_cnt = MULT_N;
    else if (mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mdl_cnt = 0;
    mdl_stall_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    mdl_cnt = 0;
    mdl_stall_cnt = 0;
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL reset_md_busy: got %b want 0", md_busy);
    else passes++;
    checks++;
    if (stall_cnt !== 32'd0) $display("[TB] FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    clear_inputs();
    DEA3 = 8; DETnew = 1; A1 = 8; Tuse_rs = 0;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL load_use_stall: got %b want 1", stall);
    else passes++;
    tick();
    clear_inputs();
    A1 = 8; Tuse_rs = 0; EMA3 = 8; EMTnew = 0;
    #1;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL load_use_release: got %b want 0", stall);
    else passes++;
    checks++;
    if (fwd_rs_d !== 2'd2) $display("[TB] FAIL load_use_fwd: got %0d want 2", fwd_rs_d);
    else passes++;
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    A1 = 5; DEA3 = 5; DETnew = 0; EMA3 = 5; EMTnew = 0; MWA3 = 5;
    DEA1 = 5; DEA2 = 5; EMA2 = 5; A2 = 5; Tuse_rt = 0;
    #1;
    checks++;
    if (fwd_rs_d !== 2'd1) $display("[TB] FAIL prio_rs_d: got %0d want 1", fwd_rs_d);
    else passes++;
    checks++;
    if (fwd_rt_d !== 2'd1) $display("[TB] FAIL prio_rt_d: got %0d want 1", fwd_rt_d);
    else passes++;
    checks++;
    if (fwd_rs_e !== 2'd2) $display("[TB] FAIL prio_rs_e: got %0d want 2", fwd_rs_e);
    else passes++;
    checks++;
    if (fwd_rt_m !== 1'b1) $display("[TB] FAIL prio_rt_m: got %b want 1", fwd_rt_m);
    else passes++;
    A1 = 0; A2 = 0; DEA1 = 0; EMA2 = 0;
    DEA3 = 0; EMA3 = 0; MWA3 = 0;
    #1;
    checks++;
    if (fwd_rs_d !== 2'd0) $display("[TB] FAIL zero_fwd_rs_d: got %0d want 0", fwd_rs_d);
    else passes++;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL zero_stall: got %b want 0", stall);
    else passes++;
    checks++;
    if (fwd_rt_m !== 1'b0) $display("[TB] FAIL zero_rt_m: got %b want 0", fwd_rt_m);
    else passes++;
    tick();
  endtask

  task automatic test_tuse_slack();
    clear_inputs();
    DEA3 = 9; DETnew = 1; A2 = 9; Tuse_rt = 1;
    #1;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL slack_stall: got %b want 0", stall);
    else passes++;
    Tuse_rt = TUSE_NONE;
    #1;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL unused_stall: got %b want 0", stall);
    else passes++;
    checks++;
    if (fwd_rt_d !== 2'd0) $display("[TB] FAIL unused_fwd_rt: got %0d want 0", fwd_rt_d);
    else passes++;
    tick();
  endtask

  task automatic test_mult_busy();
    logic [31:0] base;
    clear_inputs();
    base = mdl_stall_cnt;
    D_md = 1; E_mult = 1;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL mult_start_stall: got %b want 1", stall);
    else passes++;
    tick();
    E_mult = 0;
    for (int i = 0; i < MULT_N; i++) begin
      #1;
      checks++;
      if (md_busy !== 1'b1 || stall !== 1'b1)
        $display("[TB] FAIL mult_busy_%0d: got busy=%b stall=%b want 1/1", i, md_busy, stall);
      else passes++;
      tick();
    end
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL mult_done: got %b want 0", md_busy);
    else passes++;
    checks++;
    if (stall_cnt !== base + 32'd6)
      $display("[TB] FAIL mult_stall_cnt: got %0d want %0d", stall_cnt, base + 32'd6);
    else passes++;
    D_md = 0;
    tick();
  endtask

  task automatic test_div_reload();
    clear_inputs();
    E_mult = 1;
    tick();
    E_mult = 0;
    tick();
    tick();
    E_div = 1;
    tick();
    E_div = 0;
    for (int i = 0; i < DIV_N; i++) begin
      #1;
      checks++;
      if (md_busy !== 1'b1) $display("[TB] FAIL div_reload_%0d: got %b want 1", i, md_busy);
      else passes++;
      tick();
    end
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL div_reload_done: got %b want 0", md_busy);
    else passes++;
  endtask

  task automatic test_excclr();
    logic [31:0] base;
    clear_inputs();
    base = mdl_stall_cnt;
    E_div = 1; ExcClr = 1; D_md = 1;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL exc_stall_unmasked: got %b want 1", stall);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL exc_suppress: got %b want 0", md_busy);
    else passes++;
    checks++;
    if (stall_cnt !== base)
      $display("[TB] FAIL exc_no_count: got %0d want %0d", stall_cnt, base);
    else passes++;
    E_mult = 1;
    tick();
    E_mult = 0;
    for (int i = 0; i < MULT_N; i++) begin
      ExcClr = (i == 2);
      #1;
      checks++;
      if (md_busy !== 1'b1) $display("[TB] FAIL exc_mult_run_%0d: got %b want 1", i, md_busy);
      else passes++;
      tick();
    end
    ExcClr = 0;
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL exc_mult_done: got %b want 0", md_busy);
    else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    clear_inputs();
    DEA3 = 8; DETnew = 1; A1 = 8; Tuse_rs = 0;
    for (int i = 0; i < 96; i++) tick();
    clear_inputs();
    D_md = 1; E_div = 1;
    tick();
    E_div = 0;
    for (int i = 0; i < 3; i++) tick();
    D_md = 0;
    #1;
    checks++;
    if (stall_cnt !== 32'd100) $display("[TB] FAIL pre_reset_cnt: got %0d want 100", stall_cnt);
    else passes++;
    checks++;
    if (md_busy !== 1'b1) $display("[TB] FAIL pre_reset_busy: got %b want 1", md_busy);
    else passes++;
    #1;
    reset = 1'b1;
    mdl_cnt = 0;
    mdl_stall_cnt = 0;
    #1;
    checks++;
    if (md_busy !== 1'b0) $display("[TB] FAIL async_md_busy: got %b want 0", md_busy);
    else passes++;
    checks++;
    if (stall_cnt !== 32'd0) $display("[TB] FAIL async_stall_cnt: got %0d want 0", stall_cnt);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      A1 = 5'($urandom_range(0, 3));   A2 = 5'($urandom_range(0, 3));
      DEA1 = 5'($urandom_range(0, 3)); DEA2 = 5'($urandom_range(0, 3));
      DEA3 = 5'($urandom_range(0, 3)); EMA2 = 5'($urandom_range(0, 3));
      EMA3 = 5'($urandom_range(0, 3)); MWA3 = 5'($urandom_range(0, 3));
      Tuse_rs = 2'($urandom_range(0, 3)); Tuse_rt = 2'($urandom_range(0, 3));
      DETnew = 2'($urandom_range(0, 3));  EMTnew = 2'($urandom_range(0, 2));
      D_md = 1'($urandom_range(0, 1));
      E_mult = ($urandom_range(0, 11) == 0);
      E_div = ($urandom_range(0, 15) == 0);
      ExcClr = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (stall !== mdl_stall()) $display("[TB] FAIL rnd_stall @%0d: got %b want %b", n, stall, mdl_stall());
      else passes++;
      checks++;
      if (fwd_rs_d !== mdl_fwd_d(A1) || fwd_rt_d !== mdl_fwd_d(A2))
        $display("[TB] FAIL rnd_fwd_d @%0d: got %0d/%0d want %0d/%0d", n, fwd_rs_d, fwd_rt_d, mdl_fwd_d(A1), mdl_fwd_d(A2));
      else passes++;
      checks++;
      if (fwd_rs_e !== mdl_fwd_e(DEA1) || fwd_rt_e !== mdl_fwd_e(DEA2))
        $display("[TB] FAIL rnd_fwd_e @%0d: got %0d/%0d want %0d/%0d", n, fwd_rs_e, fwd_rt_e, mdl_fwd_e(DEA1), mdl_fwd_e(DEA2));
      else passes++;
      checks++;
      if (fwd_rt_m !== (EMA2 != 0 && EMA2 == MWA3))
        $display("[TB] FAIL rnd_fwd_m @%0d: got %b", n, fwd_rt_m);
      else passes++;
      checks++;
      if (md_busy !== (mdl_cnt > 0)) $display("[TB] FAIL rnd_md_busy @%0d: got %b want %b", n, md_busy, mdl_cnt > 0);
      else passes++;
      checks++;
      if (stall_cnt !== mdl_stall_cnt)
        $display("[TB] FAIL rnd_stall_cnt @%0d: got %0d want %0d", n, stall_cnt, mdl_stall_cnt);
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_tuse_slack();
    test_mult_busy();
    test_div_reload();
    test_excclr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer end of the A1/A2/A3/Tnew tracking pipeline in the 5-stage MIPS core.
- Compares D-stage source registers and Tuse against in-flight destinations and Tnew; produces the D-stage stall and forwarding selects for the D, E and M stages.
- Owns the mult/div busy counter, since stalls on HI/LO access depend on it.
- Keeps a free-running count of stall cycles for performance measurement.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E.
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E.
- CNT_W, 4, width of the busy counter. It must hold DIV_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  5  D-stage rs address.
- A2  in  5  D-stage rt address.
- Tuse_rs  in  2  cycles until D needs rs; 3 = not used.
- Tuse_rt  in  2  cycles until D needs rt; 3 = not used.
- D_md  in  1  D instruction reads or writes HI/LO, or is mult/div.
- DEA1  in  5  E-stage rs address.
- DEA2  in  5  E-stage rt address.
- DEA3  in  5  E-stage destination address.
- DETnew  in  2  E-stage remaining cycles until its result exists.
- EMA2  in  5  M-stage rt address.
- EMA3  in  5  M-stage destination address.
- EMTnew  in  2  M-stage remaining cycles until its result exists.
- MWA3  in  5  W-stage destination address.
- E_mult  in  1  mult/multu in E this cycle.
- E_div  in  1  div/divu in E this cycle.
- ExcClr  in  1  exception flush.
- stall  out  1  freeze F/D, bubble into E.
- fwd_rs_d  out  2  D rs source: 0 = RF, 1 = E, 2 = M, 3 = W.
- fwd_rt_d  out  2  D rt source, same encoding.
- fwd_rs_e  out  2  E rs source: 0 = reg, 2 = M, 3 = W.
- fwd_rt_e  out  2  E rt source, same encoding.
- fwd_rt_m  out  1  M rt source: 1 = W.
- md_busy  out  1  mult/div unit occupied.
- stall_cnt  out  32  number of stalled cycles.

Behaviour:
- Address 0 never matches any destination. All hazard and forward logic is combinational from the inputs and the counter state.
- stall_rs = A1≠0 and ((A1==DEA3 and DETnew>Tuse_rs) or (A1==EMA3 and EMTnew>Tuse_rs)).
- stall_rt is the same rule with A2 and Tuse_rt.
- stall_md = D_md and (md_busy or E_mult or E_div).
- stall = stall_rs | stall_rt | stall_md.
- Forward to D (rs shown; rt identical):
  - 1 if A1==DEA3 and DETnew==0;
  - else 2 if A1==EMA3 and EMTnew==0;
  - else 3 if A1==MWA3;
  - else 0.
  - Priority is strictly E > M > W: the youngest producer wins.
- Forward to E: 2 if DEA1==EMA3 and EMTnew==0, else 3 if DEA1==MWA3, else 0. Same rule for DEA2.
- Forward to M: fwd_rt_m = EMA2≠0 and EMA2==MWA3.
- Busy counter cnt (CNT_W bits), with md_busy = (cnt≠0):
  - Reset: cnt=0 immediately, asynchronously.
  - Posedge with E_div and not ExcClr: cnt ← DIV_CYCLES.
  - Else posedge with E_mult and not ExcClr: cnt ← MULT_CYCLES.
  - Else if cnt≠0: cnt ← cnt−1.
  - A start while cnt≠0 reloads the counter; it is not queued.
  - E_div has priority if both starts are asserted. That is illegal, but the result is defined.
- ExcClr:
  - Suppresses a start in the same cycle.
  - Does not cancel an already running operation; cnt keeps decrementing.
  - Does not mask the combinational stall.
- stall_cnt:
  - Reset: 0.
  - Increments by 1 each posedge where stall=1 and ExcClr=0.
  - Wraps from 2^32−1 to 0.
- Reset values: cnt=0, stall_cnt=0, md_busy=0. Combinational outputs follow their inputs during reset.
- Reset asserted mid-operation clears cnt immediately, and md_busy drops in the same cycle.

Decomposition:
- Shared package holds:
  - Forward-select encodings FWD_RF/FWD_E/FWD_M/FWD_W = 0/1/2/3.
  - TUSE_NONE = 3.
  - MULT_CYCLES and DIV_CYCLES defaults.
  - Register address width 5.
- One sub-module, md_busy_ctr: load/decrement counter producing md_busy.

Test Plan:
- Load-use: DEA3=8, DETnew=1, A1=8, Tuse_rs=0 → stall=1. Next cycle inputs EMA3=8, EMTnew=0 → stall=0, fwd_rs_d=2.
- Priority: A1=5, DEA3=5/DETnew=0, EMA3=5/EMTnew=0, MWA3=5 → fwd_rs_d=1. With A1=0 and the same destinations → fwd_rs_d=0, stall=0.
- Tuse slack: DEA3=9, DETnew=1, A2=9, Tuse_rt=1 → stall=0. With Tuse_rt=3 → stall=0, fwd_rt_d=0.
- Mult/div busy:
  - E_mult pulse → md_busy=1 for exactly 5 cycles.
  - D_md=1 during those cycles → stall=1, and stall_cnt advances by 6 (start cycle plus 5 busy cycles).
  - E_div at busy cycle 3 → reload, md_busy lasts 10 more cycles.
- ExcClr: E_div and ExcClr together → cnt stays 0. A running mult with ExcClr asserted mid-way still completes its 5-cycle count.
- Async reset: assert reset between clock edges with cnt=7 and stall_cnt=100 → md_busy=0 and stall_cnt=0 before the next edge.
